// File: rtl/mac_pkt_pkg.sv
// Shared constants and FSM state type for the Ethernet TX packet generator.
//   ETH_HDR_LEN : bytes in the dst/src/ethertype header
//   MIN_PAYLOAD : smallest payload the generator emits (shorter requests are padded up)
//   MAX_PAYLOAD : largest payload the generator emits (longer requests are cut down)
package mac_pkt_pkg;

    localparam int unsigned ETH_HDR_LEN = 14;
    localparam int unsigned MIN_PAYLOAD = 46;
    localparam int unsigned MAX_PAYLOAD = 1500;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StPayload,
        StGap
    } pkt_state_e;

endpackage

// File: rtl/mac_tx_pktgen.sv
// Ethernet frame generator driving an 8-bit AXI4-Stream MAC TX port.
// A run of frames starts with cfg_start and uses a snapshot of the configuration taken at
// that moment. Each frame is a 14-byte header followed by a counting payload pattern.
//
// Ports
//   tx_axis_clk, tx_axis_rstn   : clock, synchronous active-low reset
//   cfg_start, cfg_stop         : start pulse (IDLE only), stop level (finishes current frame)
//   cfg_frame_num               : frames per run, 0 = run until stopped
//   cfg_payload_len             : payload bytes per frame, clamped to 46..1500
//   cfg_dst_mac, cfg_src_mac    : header addresses
//   cfg_ethertype, cfg_gap      : header type field, idle cycles between frames
//   cfg_err_inject              : mark the next started frame bad via tuser on its tlast
//   tx_axis_mac_*               : registered AXI4-Stream byte output
//   busy, done, frame_cnt       : run in progress, end-of-run pulse, frames completed
module mac_tx_pktgen #(
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   tx_axis_clk,
    input  logic                   tx_axis_rstn,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [FRAME_CNT_W-1:0] cfg_frame_num,
    input  logic [10:0]            cfg_payload_len,
    input  logic [47:0]            cfg_dst_mac,
    input  logic [47:0]            cfg_src_mac,
    input  logic [15:0]            cfg_ethertype,
    input  logic [7:0]             cfg_gap,
    input  logic                   cfg_err_inject,
    output logic [7:0]             tx_axis_mac_tdata,
    output logic                   tx_axis_mac_tvalid,
    output logic                   tx_axis_mac_tlast,
    output logic                   tx_axis_mac_tuser,
    input  logic                   tx_axis_mac_tready,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    import mac_pkt_pkg::*;

    pkt_state_e             state_q, state_d;
    logic [10:0]            byte_cnt_q, byte_cnt_d;
    logic [7:0]             gap_cnt_q, gap_cnt_d;
    logic [7:0]             seq_q, seq_d;
    logic [10:0]            len_q, len_d;
    logic [FRAME_CNT_W-1:0] num_q, num_d;
    logic [47:0]            dst_q, dst_d;
    logic [47:0]            src_q, src_d;
    logic [15:0]            et_q, et_d;
    logic [7:0]             gap_q, gap_d;
    logic                   err_q, err_d;
    logic                   stop_q, stop_d;
    logic [7:0]             tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_q, tuser_d;
    logic                   done_q, done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic                   hs;
    logic [10:0]            len_clamped;
    logic [3:0]             hdr_idx;
    logic [7:0]             hdr_byte;
    logic [10:0]            pay_next;
    logic [FRAME_CNT_W:0]   cnt_plus1;
    logic                   last_frame;

    assign hs = tvalid_q & tx_axis_mac_tready;

    always_comb begin
        len_clamped = cfg_payload_len;
        if (cfg_payload_len < 11'(MIN_PAYLOAD)) begin
            len_clamped = 11'(MIN_PAYLOAD);
        end else if (cfg_payload_len > 11'(MAX_PAYLOAD)) begin
            len_clamped = 11'(MAX_PAYLOAD);
        end
    end

    // The output register always holds the byte being offered, so the mux selects the byte
    // that follows the current one.
    assign hdr_idx = byte_cnt_q[3:0] + 4'd1;

    always_comb begin
        case (hdr_idx)
            4'd0:    hdr_byte = dst_q[47:40];
            4'd1:    hdr_byte = dst_q[39:32];
            4'd2:    hdr_byte = dst_q[31:24];
            4'd3:    hdr_byte = dst_q[23:16];
            4'd4:    hdr_byte = dst_q[15:8];
            4'd5:    hdr_byte = dst_q[7:0];
            4'd6:    hdr_byte = src_q[47:40];
            4'd7:    hdr_byte = src_q[39:32];
            4'd8:    hdr_byte = src_q[31:24];
            4'd9:    hdr_byte = src_q[23:16];
            4'd10:   hdr_byte = src_q[15:8];
            4'd11:   hdr_byte = src_q[7:0];
            4'd12:   hdr_byte = et_q[15:8];
            4'd13:   hdr_byte = et_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    assign pay_next  = byte_cnt_q + 11'd1;
    assign cnt_plus1 = {1'b0, frame_cnt_q} + {{FRAME_CNT_W{1'b0}}, 1'b1};

    // Evaluated only at the tlast handshake of the frame in flight.
    assign last_frame = ((num_q != '0) && (cnt_plus1 == {1'b0, num_q})) | stop_q | cfg_stop;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        seq_d       = seq_q;
        len_d       = len_q;
        num_d       = num_q;
        dst_d       = dst_q;
        src_d       = src_q;
        et_d        = et_q;
        gap_d       = gap_q;
        err_d       = err_q;
        stop_d      = stop_q | cfg_stop;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (cfg_start) begin
                    state_d     = StHdr;
                    byte_cnt_d  = '0;
                    seq_d       = '0;
                    frame_cnt_d = '0;
                    len_d       = len_clamped;
                    num_d       = cfg_frame_num;
                    dst_d       = cfg_dst_mac;
                    src_d       = cfg_src_mac;
                    et_d        = cfg_ethertype;
                    gap_d       = cfg_gap;
                    // A stop seen together with the start limits the run to one frame.
                    stop_d      = cfg_stop;
                    err_d       = cfg_err_inject;
                    tvalid_d    = 1'b1;
                    tdata_d     = cfg_dst_mac[47:40];
                    tlast_d     = 1'b0;
                    tuser_d     = 1'b0;
                end
            end

            StHdr: begin
                if (hs) begin
                    if (byte_cnt_q == 11'(ETH_HDR_LEN - 1)) begin
                        state_d    = StPayload;
                        byte_cnt_d = '0;
                        tdata_d    = seq_q;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                        tdata_d    = hdr_byte;
                    end
                end
            end

            StPayload: begin
                if (hs) begin
                    if (tlast_q) begin
                        frame_cnt_d = (&frame_cnt_q) ? frame_cnt_q : cnt_plus1[FRAME_CNT_W-1:0];
                        seq_d       = seq_q + 8'd1;
                        byte_cnt_d  = '0;
                        tlast_d     = 1'b0;
                        tuser_d     = 1'b0;
                        if (last_frame) begin
                            state_d  = StIdle;
                            tvalid_d = 1'b0;
                            tdata_d  = 8'h00;
                            done_d   = 1'b1;
                        end else if (gap_q == 8'd0) begin
                            state_d  = StHdr;
                            tvalid_d = 1'b1;
                            tdata_d  = dst_q[47:40];
                            err_d    = cfg_err_inject;
                        end else begin
                            state_d   = StGap;
                            tvalid_d  = 1'b0;
                            tdata_d   = 8'h00;
                            gap_cnt_d = gap_q - 8'd1;
                        end
                    end else begin
                        byte_cnt_d = pay_next;
                        tdata_d    = pay_next[7:0] + seq_q;
                        tlast_d    = (pay_next == len_q - 11'd1);
                        tuser_d    = (pay_next == len_q - 11'd1) & err_q;
                    end
                end
            end

            StGap: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d    = StHdr;
                    byte_cnt_d = '0;
                    tvalid_d   = 1'b1;
                    tdata_d    = dst_q[47:40];
                    err_d      = cfg_err_inject;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge tx_axis_clk) begin
        if (!tx_axis_rstn) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            seq_q       <= '0;
            len_q       <= '0;
            num_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            et_q        <= '0;
            gap_q       <= '0;
            err_q       <= 1'b0;
            stop_q      <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            seq_q       <= seq_d;
            len_q       <= len_d;
            num_q       <= num_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            et_q        <= et_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            stop_q      <= stop_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_axis_mac_tdata  = tdata_q;
    assign tx_axis_mac_tvalid = tvalid_q;
    assign tx_axis_mac_tlast  = tlast_q;
    assign tx_axis_mac_tuser  = tuser_q;
    assign busy               = (state_q != StIdle);
    assign done               = done_q;
    assign frame_cnt          = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_pktgen.sv
// Directed, self-checking bench for mac_tx_pktgen: a table of run configurations with
// hand-computed frame sizes, plus hand-written sequences for stalls, stop/error injection
// in continuous mode, start+stop, and reset in the middle of a frame.
module tb_mac_tx_pktgen;

    localparam int          FW     = 16;
    localparam int          BUDGET = 20000;
    localparam logic [47:0] DST    = 48'hD0_11_22_33_44_55;
    localparam logic [47:0] DST2   = 48'h7E_01_02_03_04_05;
    localparam logic [47:0] SRC    = 48'hA5_5A_C3_3C_0F_F0;
    localparam logic [15:0] ET     = 16'h88B5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_start, cfg_stop, cfg_err_inject;
    logic [FW-1:0] cfg_frame_num;
    logic [10:0]   cfg_payload_len;
    logic [47:0]   cfg_dst_mac, cfg_src_mac;
    logic [15:0]   cfg_ethertype;
    logic [7:0]    cfg_gap;
    logic [7:0]    tdata;
    logic          tvalid, tlast, tuser, tready;
    logic          busy, done;
    logic [FW-1:0] frame_cnt;

    mac_tx_pktgen #(.FRAME_CNT_W(FW)) dut (
        .tx_axis_clk        (clk),
        .tx_axis_rstn       (rstn),
        .cfg_start          (cfg_start),
        .cfg_stop           (cfg_stop),
        .cfg_frame_num      (cfg_frame_num),
        .cfg_payload_len    (cfg_payload_len),
        .cfg_dst_mac        (cfg_dst_mac),
        .cfg_src_mac        (cfg_src_mac),
        .cfg_ethertype      (cfg_ethertype),
        .cfg_gap            (cfg_gap),
        .cfg_err_inject     (cfg_err_inject),
        .tx_axis_mac_tdata  (tdata),
        .tx_axis_mac_tvalid (tvalid),
        .tx_axis_mac_tlast  (tlast),
        .tx_axis_mac_tuser  (tuser),
        .tx_axis_mac_tready (tready),
        .busy               (busy),
        .done               (done),
        .frame_cnt          (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int num;
        int gap;
        int exp_len;
        int exp_frames;
    } vec_t;

    vec_t       vecs[7];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] cap_data[$];
    bit         cap_last[$];
    bit         cap_user[$];
    int         gaps[$];
    int         done_cnt = 0;
    int         frames_seen = 0;
    int         frame_byte = 0;
    bit         in_gap = 0;
    int         gap_len = 0;
    bit         stall_prev = 0;
    logic [7:0] prev_data;
    logic       prev_last, prev_user;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe the bus at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rstn) begin
            in_gap     = 0;
            frame_byte = 0;
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {tvalid, tlast, tuser, tdata},
                      {1'b1, prev_last, prev_user, prev_data});
            end
            if (in_gap) begin
                if (!tvalid) gap_len++;
                else begin
                    gaps.push_back(gap_len);
                    in_gap = 0;
                end
            end
            if (tvalid && tready) begin
                cap_data.push_back(tdata);
                cap_last.push_back(tlast);
                cap_user.push_back(tuser);
                frame_byte++;
                if (tlast) begin
                    frames_seen++;
                    frame_byte = 0;
                    in_gap     = 1;
                    gap_len    = 0;
                end
            end
            stall_prev = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            prev_user  = tuser;
            if (done) done_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int f, input int i, input logic [47:0] d);
        logic [111:0] h;
        h = {d, SRC, ET};
        if (i < 14) return h[111 - 8 * i -: 8];
        return 8'((i - 14 + f) % 256);
    endfunction

    // Starts a run, then scrambles the cfg inputs to show the run uses its snapshot.
    task automatic start_run(input int len, input int num, input int gap, input logic [47:0] d,
                             input bit stop);
        cfg_payload_len = 11'(len);
        cfg_frame_num   = FW'(num);
        cfg_gap         = 8'(gap);
        cfg_dst_mac     = d;
        cfg_src_mac     = SRC;
        cfg_ethertype   = ET;
        cfg_stop        = stop;
        cfg_start       = 1'b1;
        in_gap          = 0;
        tick();
        cfg_start       = 1'b0;
        cfg_stop        = 1'b0;
        check("tvalid_after_start", tvalid, 1);
        check("first_byte", tdata, d[47:40]);
        cfg_payload_len = 11'd300;
        cfg_frame_num   = FW'(7);
        cfg_gap         = 8'd9;
        cfg_dst_mac     = ~d;
        cfg_src_mac     = 48'h0;
        cfg_ethertype   = 16'h0800;
    endtask

    task automatic check_stream(input string name, input int base, input int gbase,
                                input int dbase, input int exp_len, input int frames,
                                input int gap, input int err_frame, input logic [47:0] d);
        int errs = 0;
        int first = -1;
        int idx;
        logic [7:0] eb;
        bit el, eu;
        check({name, "_nbytes"}, cap_data.size() - base, exp_len * frames);
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < exp_len; i++) begin
                idx = base + f * exp_len + i;
                eb  = exp_byte(f, i, d);
                el  = (i == exp_len - 1);
                eu  = el && (f == err_frame);
                if (idx >= cap_data.size() || cap_data[idx] != eb || cap_last[idx] != el ||
                    cap_user[idx] != eu) begin
                    errs++;
                    if (first < 0) begin
                        first = idx - base;
                        $display("  %s: first bad beat %0d (frame %0d byte %0d), want %02h/%0b/%0b",
                                 name, first, f, i, eb, el, eu);
                    end
                end
            end
        end
        check({name, "_bad_beats"}, errs, 0);
        check({name, "_ngaps"}, gaps.size() - gbase, frames - 1);
        for (int g = gbase; g < gaps.size(); g++) check({name, "_gap_len"}, gaps[g], gap);
        check({name, "_done_pulses"}, done_cnt - dbase, 1);
        check({name, "_frame_cnt"}, frame_cnt, frames);
        check({name, "_busy_after"}, busy, 0);
    endtask

    task automatic run_check(input string name, input int len, input int num, input int gap,
                             input int exp_len, input int frames, input bit stop0,
                             input bit rnd, input logic [47:0] d);
        int  base  = cap_data.size();
        int  gbase = gaps.size();
        int  dbase = done_cnt;
        int  n     = 0;
        bit  pulsed = 0;
        start_run(len, num, gap, d, stop0);
        while (!done && n < BUDGET) begin
            cfg_start = 1'b0;
            // A start while busy must be ignored.
            if (stop0 && !pulsed && cap_data.size() - base >= 5) begin
                cfg_start = 1'b1;
                pulsed    = 1;
            end
            if (rnd) tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        cfg_start = 1'b0;
        tready    = 1'b1;
        check({name, "_done_seen"}, done, 1);
        tick();
        tick();
        check_stream(name, base, gbase, dbase, exp_len, frames, gap, -1, d);
        if (cap_data.size() - base >= exp_len) begin
            check({name, "_pay0"}, cap_data[base + 14], 8'h00);
            check({name, "_paylast"}, cap_data[base + exp_len - 1], (exp_len - 15) % 256);
            check({name, "_paylast_tlast"}, cap_last[base + exp_len - 1], 1);
        end
    endtask

    initial begin
        int base, gbase, dbase, fbase, n, fr;

        vecs[0] = '{len: 46,   num: 1, gap: 0, exp_len: 60,   exp_frames: 1};
        vecs[1] = '{len: 10,   num: 1, gap: 0, exp_len: 60,   exp_frames: 1};
        vecs[2] = '{len: 2000, num: 1, gap: 2, exp_len: 1514, exp_frames: 1};
        vecs[3] = '{len: 46,   num: 3, gap: 5, exp_len: 60,   exp_frames: 3};
        vecs[4] = '{len: 100,  num: 2, gap: 0, exp_len: 114,  exp_frames: 2};
        vecs[5] = '{len: 1500, num: 2, gap: 1, exp_len: 1514, exp_frames: 2};
        vecs[6] = '{len: 47,   num: 2, gap: 1, exp_len: 61,   exp_frames: 2};

        rstn            = 1'b0;
        cfg_start       = 1'b0;
        cfg_stop        = 1'b0;
        cfg_err_inject  = 1'b0;
        cfg_frame_num   = '0;
        cfg_payload_len = '0;
        cfg_dst_mac     = '0;
        cfg_src_mac     = '0;
        cfg_ethertype   = '0;
        cfg_gap         = '0;
        tready          = 1'b1;
        repeat (3) tick();
        check("rst_bus", {tvalid, tlast, tuser, tdata}, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rstn = 1'b1;
        tick();
        check("idle_no_valid", tvalid, 0);

        foreach (vecs[v]) begin
            run_check($sformatf("vec%0d", v), vecs[v].len, vecs[v].num, vecs[v].gap,
                      vecs[v].exp_len, vecs[v].exp_frames, 1'b0, 1'b0, DST);
        end

        // Backpressure: random tready must not change the byte stream.
        run_check("stall", 50, 2, 3, 64, 2, 1'b0, 1'b1, DST);

        // Start with stop in IDLE and continuous count: exactly one frame.
        run_check("start_stop", 100, 0, 1, 114, 1, 1'b1, 1'b0, DST);

        // Continuous mode: error on frame 2, stop raised inside frame 4.
        base  = cap_data.size();
        gbase = gaps.size();
        dbase = done_cnt;
        fbase = frames_seen;
        start_run(46, 0, 2, DST, 1'b0);
        n = 0;
        while (!done && n < 3000) begin
            fr = frames_seen - fbase;
            if (fr == 1 && frame_byte >= 30) cfg_err_inject = 1'b1;
            if (fr == 2 && frame_byte >= 10) cfg_err_inject = 1'b0;
            if (fr == 4 && frame_byte >= 20) cfg_stop = 1'b1;
            tick();
            n++;
        end
        check("cont_done_seen", done, 1);
        cfg_stop       = 1'b0;
        cfg_err_inject = 1'b0;
        tick();
        tick();
        check_stream("cont", base, gbase, dbase, 60, 5, 2, 2, DST);

        // Reset while payload byte 20 is on the bus.
        base  = cap_data.size();
        fbase = frames_seen;
        start_run(46, 1, 0, DST, 1'b0);
        n = 0;
        while (cap_data.size() - base < 34 && n < 500) begin
            tick();
            n++;
        end
        check("rst_mid_reached", cap_data.size() - base, 34);
        check("rst_mid_byte", tdata, 8'd20);
        rstn = 1'b0;
        tick();
        check("rst_mid_bus", {tvalid, tlast, tuser, tdata}, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_frame_cnt", frame_cnt, 0);
        rstn = 1'b1;
        tick();
        check("rst_mid_no_tlast", frames_seen - fbase, 0);
        check("rst_mid_idle", {busy, tvalid}, 0);
        run_check("after_rst", 46, 1, 0, 60, 1, 1'b0, 1'b0, DST2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_tx_pktgen.md
MAC_TX_PKTGEN -- requirements
Module: mac_tx_pktgen

Interface
REQ-001 Parameter: FRAME_CNT_W, 16, width of cfg_frame_num and frame_cnt.
REQ-002 tx_axis_clk  in  1  sole clock; all logic rises on it.
REQ-003 tx_axis_rstn  in  1  reset; synchronous, active-low.
REQ-004 cfg_start  in  1  one-cycle start pulse; honoured only in IDLE.
REQ-005 cfg_stop  in  1  level; finish current frame, then stop.
REQ-006 cfg_frame_num  in  FRAME_CNT_W  frames to send; 0 = continuous.
REQ-007 cfg_payload_len  in  11  payload bytes per frame.
REQ-008 cfg_dst_mac / cfg_src_mac  in  48 each  header addresses.
REQ-009 cfg_ethertype  in  16  header type/length field.
REQ-010 cfg_gap  in  8  idle cycles between frames.
REQ-011 cfg_err_inject  in  1  mark the next started frame bad.
REQ-012 tx_axis_mac_tdata  out  8  frame byte.
REQ-013 tx_axis_mac_tvalid / tlast / tuser  out  1 each  AXI4-Stream valid, last byte, frame-error flag.
REQ-014 tx_axis_mac_tready  in  1  MAC accepts the byte.
REQ-015 busy  out  1  high outside IDLE.
REQ-016 done  out  1  one-cycle pulse at run completion.
REQ-017 frame_cnt  out  FRAME_CNT_W  frames completed in the current run.

Function
REQ-018 FSM states: IDLE, HDR, PAYLOAD, GAP. Transitions: IDLE->HDR on cfg_start; HDR->PAYLOAD after byte 13 handshakes; PAYLOAD->GAP or IDLE after the tlast handshake; GAP->HDR when the gap count expires.
REQ-019 At cfg_start, latch cfg_payload_len clamped to 46..1500, plus cfg_frame_num, MACs, ethertype and gap; cfg changes mid-run have no effect.
REQ-020 Outputs are registered. tvalid rises the cycle after cfg_start.
REQ-021 Handshake is tvalid & tready. While tvalid=1 and tready=0, tdata, tlast and tuser hold stable.
REQ-022 Header byte order, MSB first: dst_mac[47:40] .. dst_mac[7:0], src_mac[47:40] .. src_mac[7:0], ethertype[15:8], ethertype[7:0].
REQ-023 Payload byte k (k = 0..len-1) = (k + seq) mod 256, where seq is the frame index in the run, starting at 0.
REQ-024 tlast=1 only on the last payload byte. Frame length = 14 + clamped len.
REQ-025 tuser = tlast & err_flag. err_flag samples cfg_err_inject at each frame's first byte.
REQ-026 frame_cnt clears at cfg_start, increments on each tlast handshake, and saturates at all-ones.
REQ-027 GAP holds tvalid=0 for exactly cfg_gap cycles after the tlast handshake. With cfg_gap=0, the next header byte is valid the cycle after tlast.
REQ-028 The run ends at the tlast handshake when frame_cnt+1 = cfg_frame_num (nonzero), or when cfg_stop=1. The FSM then goes to IDLE and done pulses the next cycle; no trailing gap.
REQ-029 Continuous mode (cfg_frame_num=0) runs until cfg_stop. A stop asserted mid-frame still completes that frame.
REQ-030 cfg_start while busy is ignored. cfg_start together with cfg_stop in IDLE starts a run of exactly one frame.
REQ-031 seq wraps modulo 256 without error.

Reset
REQ-032 While tx_axis_rstn=0 at a clock edge: FSM=IDLE; tdata=0; tvalid=0; tlast=0; tuser=0; busy=0; done=0; frame_cnt=0; all counters and latches zero.
REQ-033 Reset mid-frame aborts the frame immediately. No tlast is emitted.

Structure
REQ-034 Package mac_pkt_pkg holds ETH_HDR_LEN=14, MIN_PAYLOAD=46, MAX_PAYLOAD=1500 and the FSM state enum.
REQ-035 Single module, no sub-module. The header byte selector is an inline mux indexed by the byte counter.

Verification
REQ-036 len=46, num=1, gap=0, tready=1 -> 60 beats; bytes 0-13 = header; byte 14=0x00, byte 59=0x2D with tlast; done pulses; frame_cnt=1.
REQ-037 len=10 and len=2000 -> frames of 60 and 1514 bytes respectively.
REQ-038 num=3, gap=5 -> 3 frames; exactly 5 tvalid-low cycles between frames; frame 2 byte 14 = 0x02; frame_cnt=3.
REQ-039 Random tready toggling -> tdata/tlast stable while stalled; byte stream identical to the tready=1 run.
REQ-040 num=0, cfg_stop raised mid-frame 4 -> frame 4 completes, done pulses, frame_cnt=5; err_inject on frame 2 -> tuser=1 only on frame 2's tlast.
REQ-041 Reset asserted at payload byte 20 -> next cycle tvalid=0, busy=0, frame_cnt=0; a later cfg_start restarts at byte dst_mac[47:40].
